// File: rtl/bit_stuff_tx.sv
// rtl/bit_stuff_tx.sv - serial frame transmitter with SOF/EOF markers and run-limit bit stuffing
module bit_stuff_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       sout,
  output logic       sout_en,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, SOF, DATA, EOF} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] idx_q, idx_d;
  logic       last_q, last_d;
  logic       run_bit_q, run_bit_d;
  logic [1:0] run_cnt_q, run_cnt_d;
  logic       sout_q, sout_d;
  logic       sout_en_q, sout_en_d;
  logic       frame_done_q, frame_done_d;

  logic       stuff;
  logic       cur_bit;
  logic       ready_raw;
  logic       accept;

  // State registers describe the bit on the line this cycle; stuff is decided from them.
  assign stuff     = (run_cnt_q == 2'd3);
  assign cur_bit   = stuff ? ~run_bit_q : shreg_q[idx_q];
  assign ready_raw = (state_q == IDLE) ||
                     ((state_q == DATA) && !stuff && (idx_q == 3'd7) && !last_q);
  assign din_ready = ready_raw && !reset;
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    idx_d        = idx_q;
    last_d       = last_q;
    run_bit_d    = run_bit_q;
    run_cnt_d    = run_cnt_q;
    sout_d       = 1'b0;
    sout_en_d    = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = din;
          last_d  = din_last;
          idx_d   = 3'd0;
          cnt_d   = 2'd0;
          state_d = SOF;
        end
      end
      SOF: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          run_bit_d = 1'b1;
          run_cnt_d = 2'd3;
          state_d   = DATA;
        end
      end
      DATA: begin
        // A stuff bit always differs from run_bit, so the count can never pass 3.
        if (cur_bit == run_bit_q) begin
          run_cnt_d = run_cnt_q + 2'd1;
        end else begin
          run_bit_d = cur_bit;
          run_cnt_d = 2'd1;
        end
        if (!stuff) begin
          if (idx_q == 3'd7) begin
            if (accept) begin
              shreg_d = din;
              last_d  = din_last;
              idx_d   = 3'd0;
            end else begin
              cnt_d   = 2'd0;
              state_d = EOF;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      EOF: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle state.
    case (state_d)
      SOF: begin
        sout_d    = 1'b1;
        sout_en_d = 1'b1;
      end
      DATA: begin
        sout_d    = (run_cnt_d == 2'd3) ? ~run_bit_d : shreg_d[idx_d];
        sout_en_d = 1'b1;
      end
      EOF: begin
        sout_en_d    = 1'b1;
        frame_done_d = (cnt_d == 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      shreg_q      <= 8'd0;
      idx_q        <= 3'd0;
      last_q       <= 1'b0;
      run_bit_q    <= 1'b0;
      run_cnt_q    <= 2'd0;
      sout_q       <= 1'b0;
      sout_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      run_bit_q    <= run_bit_d;
      run_cnt_q    <= run_cnt_d;
      sout_q       <= sout_d;
      sout_en_q    <= sout_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sout       = sout_q;
  assign sout_en    = sout_en_q;
  assign frame_done = frame_done_q;

endmodule
